// File: rtl/sp_ram_be_init.sv
// sp_ram_be_init: generic single-port on-chip scratch RAM.
//
// Parametrised depth/width, byte-enable writes, selectable read-during-write
// response, optional output register and a hardware sweep that fills the
// array with INIT_VALUE after reset or on a clear pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      pulse while ready: re-initialise the whole array
//   req_valid  request present
//   req_ready  request can be accepted this cycle (combinational)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte enables, bit i covers bits [8i+7:8i]
//   rd_valid   one-cycle pulse, rd_data/rd_err valid
//   rd_data    response data, holds between pulses
//   rd_err     response address was out of range
//   busy       high while the init sweep runs

module sp_ram_be_init #(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           DEPTH      = 256,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           RDW_MODE   = 0,
   parameter int unsigned           OUT_REG    = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   req_be,
   output logic                      rd_valid,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_err,
   output logic                      busy
);

   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CMP_W = ADDR_WIDTH + 1;

   // Elaboration-time parameter sanity
   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_dw
      $error("sp_ram_be_init: DATA_WIDTH must be a non-zero multiple of 8");
   end
   if (DEPTH == 0 || CMP_W'(DEPTH) > (CMP_W'(1) << ADDR_WIDTH)) begin : g_bad_depth
      $error("sp_ram_be_init: DEPTH must be in 1..2**ADDR_WIDTH");
   end
   if (RDW_MODE > 2) begin : g_bad_rdw
      $error("sp_ram_be_init: RDW_MODE must be 0, 1 or 2");
   end

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        init_cnt_q, init_cnt_d;
   logic                    busy_q;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    accept;
   logic                    in_range;
   logic [CNT_W-1:0]        idx;
   logic                    wr_en;
   logic [DATA_WIDTH-1:0]   old_word;
   logic [DATA_WIDTH-1:0]   merged_word;
   logic                    resp_fire;
   logic [DATA_WIDTH-1:0]   resp_data;
   logic                    resp_err;

   logic                    s1_valid_q;
   logic [DATA_WIDTH-1:0]   s1_data_q;
   logic                    s1_err_q;

   // Request handshake: only in READY, and never in a clear cycle
   assign req_ready = (state_q == ST_READY) && !clear;
   assign accept    = req_valid && req_ready;

   // Range check done one bit wider so DEPTH == 2**ADDR_WIDTH still works
   assign in_range  = CMP_W'(req_addr) < CMP_W'(DEPTH);
   assign idx       = CNT_W'(req_addr);
   assign wr_en     = accept && req_we && in_range;

   assign old_word  = mem_q[idx];

   // Post-write word, used for the RDW_MODE 1 response
   always_comb begin
      merged_word = old_word;
      for (int unsigned b = 0; b < BE_W; b++) begin
         if (req_be[b]) begin
            merged_word[8*b +: 8] = req_wdata[8*b +: 8];
         end
      end
   end

   // Response generation; mode 2 suppresses responses to writes
   always_comb begin
      resp_fire = accept && (!req_we || (RDW_MODE != 2));
      resp_err  = !in_range;
      resp_data = '0;
      if (in_range) begin
         if (req_we && (RDW_MODE == 1)) begin
            resp_data = merged_word;
         end else begin
            resp_data = old_word;
         end
      end
   end

   // Next-state logic for the init sweep / ready FSM
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_INIT: begin
            // clear is ignored here; the sweep is never restarted
            if (init_cnt_q == CNT_W'(DEPTH - 1)) begin
               state_d    = ST_READY;
               init_cnt_d = '0;
            end else begin
               init_cnt_d = init_cnt_q + CNT_W'(1);
            end
         end
         ST_READY: begin
            if (clear) begin
               state_d    = ST_INIT;
               init_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_INIT;
            init_cnt_d = '0;
         end
      endcase
   end

   // Control and first response stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         busy_q     <= 1'b1;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         busy_q     <= (state_d == ST_INIT);
         s1_valid_q <= resp_fire;
         if (resp_fire) begin
            s1_data_q <= resp_data;
            s1_err_q  <= resp_err;
         end
      end
   end

   // Storage array: not reset, contents come only from the sweep or writes
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem_q[init_cnt_q] <= INIT_VALUE;
      end else if (wr_en) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (req_be[b]) begin
               mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   // Optional output pipeline register
   if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_valid_q;
      logic [DATA_WIDTH-1:0] s2_data_q;
      logic                  s2_err_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
         end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q <= s1_data_q;
               s2_err_q  <= s1_err_q;
            end
         end
      end

      assign rd_valid = s2_valid_q;
      assign rd_data  = s2_data_q;
      assign rd_err   = s2_err_q;
   end else begin : g_no_out_reg
      assign rd_valid = s1_valid_q;
      assign rd_data  = s1_data_q;
      assign rd_err   = s1_err_q;
   end

   assign busy = busy_q;

endmodule

// File: doc/sp_ram_be_init.md
Name: sp_ram_be_init

Overview:
- Parametrised successor to the team's 8x256 single-port RAM.
- Generalised depth and width; byte-enable writes; selectable read-during-write mode; optional output register.
- Hardware zero-initialisation after reset or on demand.
- Valid/ready request port; sits behind bus adapters and accelerator datapaths as the generic on-chip scratch memory.

Parameters:
- ADDR_WIDTH, 8, address bits.
- DEPTH, 256, number of words; DEPTH <= 2**ADDR_WIDTH; need not be a power of two.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- RDW_MODE, 0, response to a write: 0 = old word returned, 1 = new merged word returned, 2 = no read response.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- INIT_VALUE, 0, DATA_WIDTH-bit word written to every location during init.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  pulse in READY state: re-initialise the whole array.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- rd_valid  out  1  one-cycle pulse: rd_data/rd_err valid.
- rd_data  out  DATA_WIDTH  read response data.
- rd_err  out  1  qualifies rd_valid: address out of range.
- busy  out  1  high while initialising.

Behaviour:
- Reset values: rd_valid=0, rd_data=0, rd_err=0, busy=1, req_ready=0, state=INIT, init counter=0.
- Reset does not touch the array directly; contents are cleared only by the INIT sweep.
- States: INIT and READY.
- INIT:
  - Each cycle writes INIT_VALUE to address init_cnt, then increments init_cnt.
  - After writing DEPTH-1, the next state is READY. INIT lasts exactly DEPTH cycles.
  - busy=1 and req_ready=0 throughout.
  - clear is ignored; the counter is not restarted.
- READY:
  - busy=0.
  - req_ready = !clear (combinational).
  - clear=1 moves to INIT next cycle with init_cnt=0. A request presented in the same cycle is not accepted and must be held by the requester.
- Accept: req_valid && req_ready. No queue; one request per cycle at full throughput.
- Write (req_we=1):
  - Only bytes with req_be=1 are updated; other bytes keep their old value.
  - req_be=0 with req_we=1 is a legal no-op write and still produces the RDW response.
- Read (req_we=0): returns the stored word.
- Response timing:
  - rd_valid pulses exactly 1+OUT_REG cycles after accept, with rd_data and rd_err.
  - Back-to-back accepts give back-to-back rd_valid in order.
  - rd_data holds its last value when rd_valid=0.
- RDW on writes:
  - mode 0: response carries the pre-write word.
  - mode 1: response carries the byte-merged post-write word.
  - mode 2: no rd_valid for the write; rd_data unchanged.
- Out of range (req_addr >= DEPTH):
  - Write is dropped with no array change.
  - Read, or a write in modes 0/1, responds with rd_data=0 and rd_err=1.
  - In mode 2, an out-of-range write produces no response.
  - rd_err=0 for all in-range responses.
- Reads in flight when clear is taken still complete with their normal timing and data.
- Read of an address in the same cycle it is accepted after a write in the previous cycle returns the written data (no stale forwarding hazard; the array is updated first).
- rst_n asserted mid-INIT or mid-traffic:
  - All outputs return to reset values immediately; pending responses are discarded.
  - INIT restarts from address 0 after deassertion.

Test Plan:
- Reset release, DEPTH=16, DATA_WIDTH=32, INIT_VALUE=0 -> busy=1 and req_ready=0 for exactly 16 cycles, then busy=0; reads of addresses 0..15 all return 0x00000000 with rd_err=0.
- OUT_REG=0 then 1: write 0xDEADBEEF to address 5, then read address 5 -> rd_valid 1 (resp. 2) cycles after accept with rd_data=0xDEADBEEF; 4 back-to-back reads give 4 consecutive rd_valid pulses in order.
- Byte enables: address 3 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 -> subsequent read returns 0x11BB33DD.
- RDW modes, address 3 holding 0x11BB33DD, full write of 0x55667788 -> mode 0 response 0x11BB33DD; mode 1 response 0x55667788; mode 2 no rd_valid.
- Out of range, DEPTH=12: write to address 13 followed by read of address 13 -> rd_err=1 with rd_data=0; address 11 is unchanged.
- clear asserted with req_valid high in READY -> req_ready=0 that cycle, busy=1 for 16 cycles, all data reads 0 afterwards; rst_n pulsed at init_cnt=7 -> a full 16-cycle INIT occurs after release.
